// File: rtl/bus_select_arbiter.sv
// Registered bus-source select arbiter with valid flag, multi-source conflict detection, and a grant hold.
// Define BUS_SEL_ARB_RR_EN for round-robin arbitration; the default build grants the highest set index.
module bus_select_arbiter #(
  parameter  int NUM_SRC = 24,
  parameter  int CNT_W   = 8,
  localparam int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic               hold,
  input  logic               cnt_clr,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               conflict,
  output logic [CNT_W-1:0]   conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HELD  = 2'd2
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] pick;
  logic             any_req;
  logic             multi_req;

  assign any_req   = |src_en;
  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign multi_req = |(src_en & (src_en - NUM_SRC'(1)));

`ifdef BUS_SEL_ARB_RR_EN
  logic [SEL_W-1:0] rr_ptr;
  int               idx;

  // Scan downward in distance so the last hit is the nearest set bit above rr_ptr.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pick = '0;
    idx  = 0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (src_en[SEL_W'(idx)]) pick = SEL_W'(idx);
    end
  end
`else
  always_comb begin
    pick = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_en[SEL_W'(i)]) pick = SEL_W'(i);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= IDLE;
      sel          <= '0;
      sel_valid    <= 1'b0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
`ifdef BUS_SEL_ARB_RR_EN
      rr_ptr       <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      conflict <= multi_req;
      if (cnt_clr) begin
        conflict_cnt <= '0;
      end else if (multi_req && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end

      // hold only matters once a grant exists; in IDLE it is ignored.
      if ((state != IDLE) && hold) begin
        state <= HELD;
      end else if (any_req) begin
        state     <= GRANT;
        sel       <= pick;
        sel_valid <= 1'b1;
`ifdef BUS_SEL_ARB_RR_EN
        rr_ptr    <= pick;
`endif
      end else begin
        state     <= IDLE;
        sel_valid <= 1'b0;
      end
    end
  end

endmodule
